// File: rtl/rename_unit_pkg.sv
// Shared types and default sizes for the Qu rename stage.
package qu_common;

  localparam int ARCH_REGS_DEFAULT  = 32;
  localparam int PHY_REGS_DEFAULT   = 64;
  localparam int RES_ST_OP_WIDTH    = 16;
  localparam int PHY_RF_ADDR_WIDTH  = $clog2(PHY_REGS_DEFAULT);
  localparam int ARCH_RF_ADDR_WIDTH = $clog2(ARCH_REGS_DEFAULT);

  typedef logic [PHY_RF_ADDR_WIDTH-1:0]  phy_reg_t;
  typedef logic [ARCH_RF_ADDR_WIDTH-1:0] arch_reg_t;

  typedef struct packed {
    phy_reg_t                   p_rs1;
    phy_reg_t                   p_rs2;
    phy_reg_t                   p_rd;
    phy_reg_t                   p_old_rd;
    logic                       rd_wr;
    logic                       rs1_busy;
    logic                       rs2_busy;
    logic [31:0]                vj;
    logic [31:0]                vk;
    logic [RES_ST_OP_WIDTH-1:0] op;
  } rename_out_t;

endpackage

// File: rtl/rename_unit_free_list.sv
// Circular FIFO of free physical register tags, reset-filled with BASE..BASE+DEPTH-1.
module free_list #(
  parameter  int DEPTH = 32,
  parameter  int WIDTH = 6,
  parameter  int BASE  = 32,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_ptr;
  logic [WIDTH-1:0] wr_ptr;
  logic             full;
  logic             push_ok;

  function automatic logic [WIDTH-1:0] wrap_inc(input logic [WIDTH-1:0] p);
    return (p == WIDTH'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign push_ok = push && !full;
  assign head    = mem[rd_ptr[IW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= WIDTH'(BASE + i);
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= CW'(DEPTH);
    end else begin
      assert (!(push && full));
      if (push_ok) begin
        mem[wr_ptr[IW-1:0]] <= push_data;
        wr_ptr              <= wrap_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= wrap_inc(rd_ptr);
      end
      count <= count + CW'(push_ok) - CW'(pop);
    end
  end

endmodule

// File: rtl/rename_unit.sv
// Register rename stage: RAT, busy table and free list, with a registered
// valid/ready output that keeps snooping writebacks while stalled.
module rename_unit import qu_common::*; #(
  parameter  int ARCH_REGS = ARCH_REGS_DEFAULT,
  parameter  int PHY_REGS  = PHY_REGS_DEFAULT,
  parameter  int OP_WIDTH  = RES_ST_OP_WIDTH,
  localparam int AW        = $clog2(ARCH_REGS),
  localparam int PW        = $clog2(PHY_REGS),
  localparam int FL_DEPTH  = PHY_REGS - ARCH_REGS,
  localparam int FCW       = $clog2(FL_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [AW-1:0]       in_rs1,
  input  logic [AW-1:0]       in_rs2,
  input  logic [AW-1:0]       in_rd,
  input  logic                in_rd_wr,
  input  logic [OP_WIDTH-1:0] in_op,
  output logic [PW-1:0]       prf_rs1_addr,
  output logic [PW-1:0]       prf_rs2_addr,
  input  logic [31:0]         prf_rs1_data,
  input  logic [31:0]         prf_rs2_data,
  input  logic                wb_valid,
  input  logic [PW-1:0]       wb_preg,
  input  logic [31:0]         wb_data,
  input  logic                commit_valid,
  input  logic [PW-1:0]       commit_old_preg,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PW-1:0]       out_p_rs1,
  output logic [PW-1:0]       out_p_rs2,
  output logic [PW-1:0]       out_p_rd,
  output logic [PW-1:0]       out_p_old_rd,
  output logic                out_rd_wr,
  output logic                out_rs1_busy,
  output logic                out_rs2_busy,
  output logic [31:0]         out_vj,
  output logic [31:0]         out_vk,
  output logic [OP_WIDTH-1:0] out_op
);

  typedef struct packed {
    logic [PW-1:0]       p_rs1;
    logic [PW-1:0]       p_rs2;
    logic [PW-1:0]       p_rd;
    logic [PW-1:0]       p_old_rd;
    logic                rd_wr;
    logic                rs1_busy;
    logic                rs2_busy;
    logic [31:0]         vj;
    logic [31:0]         vk;
    logic [OP_WIDTH-1:0] op;
  } out_reg_t;

  logic [PW-1:0]       rat [ARCH_REGS];
  logic [PHY_REGS-1:0] busy;
  out_reg_t            out_q;
  out_reg_t            out_d;

  logic [PW-1:0]  p_rs1;
  logic [PW-1:0]  p_rs2;
  logic [PW-1:0]  fl_head;
  logic [FCW-1:0] fl_count;
  logic           alloc_needed;
  logic           accept;
  logic           do_alloc;
  logic           wb_hit1;
  logic           wb_hit2;
  logic           commit_push;

  assign p_rs1        = rat[in_rs1];
  assign p_rs2        = rat[in_rs2];
  assign prf_rs1_addr = p_rs1;
  assign prf_rs2_addr = p_rs2;

  assign alloc_needed = in_rd_wr && (in_rd != '0);
  assign in_ready     = (!out_valid || out_ready) && (!alloc_needed || (fl_count != '0));
  assign accept       = in_valid && in_ready;
  assign do_alloc     = accept && alloc_needed;
  assign commit_push  = commit_valid && (commit_old_preg != '0);

  assign wb_hit1 = wb_valid && (wb_preg == p_rs1);
  assign wb_hit2 = wb_valid && (wb_preg == p_rs2);

  free_list #(
    .DEPTH(FL_DEPTH),
    .WIDTH(PW),
    .BASE (ARCH_REGS)
  ) u_fl (
    .clk      (clk),
    .rst      (rst),
    .push     (commit_push),
    .push_data(commit_old_preg),
    .pop      (do_alloc),
    .head     (fl_head),
    .count    (fl_count)
  );

  always_comb begin
    out_d = out_q;
    if (accept) begin
      out_d.p_rs1    = p_rs1;
      out_d.p_rs2    = p_rs2;
      out_d.p_rd     = do_alloc ? fl_head : '0;
      out_d.p_old_rd = do_alloc ? rat[in_rd] : '0;
      out_d.rd_wr    = in_rd_wr;
      out_d.rs1_busy = busy[p_rs1] && !wb_hit1 && (p_rs1 != '0);
      out_d.rs2_busy = busy[p_rs2] && !wb_hit2 && (p_rs2 != '0);
      out_d.vj       = wb_hit1 ? wb_data : prf_rs1_data;
      out_d.vk       = wb_hit2 ? wb_data : prf_rs2_data;
      out_d.op       = in_op;
    end else if (out_valid && !out_ready && wb_valid) begin
      // A stalled uop keeps capturing producer results so it leaves with current operands.
      if (out_q.rs1_busy && (wb_preg == out_q.p_rs1)) begin
        out_d.rs1_busy = 1'b0;
        out_d.vj       = wb_data;
      end
      if (out_q.rs2_busy && (wb_preg == out_q.p_rs2)) begin
        out_d.rs2_busy = 1'b0;
        out_d.vk       = wb_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ARCH_REGS; i++) begin
        rat[i] <= PW'(i);
      end
      busy      <= '0;
      out_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_q     <= out_d;
      out_valid <= accept || (out_valid && !out_ready);
      if (wb_valid) begin
        busy[wb_preg] <= 1'b0;
      end
      // Allocation is written last so it wins over a writeback to the same tag.
      if (do_alloc) begin
        busy[fl_head] <= 1'b1;
        rat[in_rd]    <= fl_head;
      end
    end
  end

  assign out_p_rs1    = out_q.p_rs1;
  assign out_p_rs2    = out_q.p_rs2;
  assign out_p_rd     = out_q.p_rd;
  assign out_p_old_rd = out_q.p_old_rd;
  assign out_rd_wr    = out_q.rd_wr;
  assign out_rs1_busy = out_q.rs1_busy;
  assign out_rs2_busy = out_q.rs2_busy;
  assign out_vj       = out_q.vj;
  assign out_vk       = out_q.vk;
  assign out_op       = out_q.op;

endmodule
